registrador_universal: RTL and testbench

//  Parametrised universal register: parallel load, clear, logical shift left/right with serial in,

---
 rtl/registrador_pkg.sv | 24 ++
 rtl/registrador_prox_estado.sv | 30 +++
 rtl/registrador_universal.sv | 56 +++++
 tb/tb_registrador_universal.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/registrador_pkg.sv
// Shared types and limits for the universal register and its next-state helper.
package registrador_pkg;

    localparam int unsigned MODE_W    = 3;
    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 64;

    typedef enum logic [MODE_W-1:0] {
        M_HOLD = 3'b000,
        M_LOAD = 3'b001,
        M_SHL  = 3'b010,
        M_SHR  = 3'b011,
        M_ROL  = 3'b100,
        M_ROR  = 3'b101,
        M_INC  = 3'b110,
        M_DEC  = 3'b111
    } mode_t;

    // Terminal-count condition: the cycle before an INC or DEC wraps around.
    function automatic logic is_terminal(input mode_t mode, input logic all_ones, input logic all_zero);
        return ((mode == M_INC) && all_ones) || ((mode == M_DEC) && all_zero);
    endfunction

endpackage

// File: rtl/registrador_prox_estado.sv
// Combinational next-state for the universal register: value q takes if the operation is enabled.
module registrador_prox_estado
    import registrador_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q_next
);

    // Every mode encoding is decoded, so no value can leave q_next unassigned.
    always_comb begin
        q_next = q;
        unique case (mode)
            M_HOLD: q_next = q;
            M_LOAD: q_next = d;
            M_SHL:  q_next = {q[WIDTH-2:0], sin_r};
            M_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
            M_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            M_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            M_INC:  q_next = q + WIDTH'(1);
            M_DEC:  q_next = q - WIDTH'(1);
        endcase
    end

endmodule

// File: rtl/registrador_universal.sv
// Parametrised universal register: load, clear, shift, rotate and wrap-around count,
// with serial outputs and terminal count for chaining into wider registers.
module registrador_universal
    import registrador_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter logic [63:0] RST_VAL = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             tc,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] q_next;

    registrador_prox_estado #(
        .WIDTH (WIDTH)
    ) u_prox_estado (
        .q      (q),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q_next (q_next)
    );

    // Priority: rst, then clr, then enable; mode only matters when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RST_Q;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= q_next;
        end
    end

    // Status outputs follow q directly so a downstream en can be driven from tc.
    assign sout_l = q[WIDTH-1];
    assign sout_r = q[0];
    assign zero   = (q == '0);
    assign tc     = en & is_terminal(mode, &q, zero);

endmodule

// File: tb/tb_registrador_universal.sv
// Randomised scoreboard bench for registrador_universal: 8-bit, 2-bit and a cascaded 16-bit pair.
module tb_registrador_universal;
    import registrador_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, clr = 1'b0, en = 1'b0;
    mode_t      mode = M_HOLD;
    logic [7:0] d = 8'h00;
    logic       sin_r = 1'b0, sin_l = 1'b0;
    logic       c_rst = 1'b1, c_en = 1'b0;
    mode_t      c_mode = M_INC;
    logic       c_zero_in = 1'b0;
    logic [7:0] c_d = 8'h00;

    logic [7:0] q8;  logic sl8, sr8, tc8, z8;
    logic [1:0] q2;  logic sl2, sr2, tc2, z2;
    logic [7:0] qlo; logic sllo, srlo, tclo, zlo;
    logic [7:0] qhi; logic slhi, srhi, tchi, zhi;

    registrador_universal #(.WIDTH(8), .RST_VAL(64'hA5)) dut8 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d),
        .sin_r(sin_r), .sin_l(sin_l), .q(q8), .sout_l(sl8), .sout_r(sr8), .tc(tc8), .zero(z8));

    registrador_universal #(.WIDTH(2), .RST_VAL(64'h6)) dut2 (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .mode(mode), .d(d[1:0]),
        .sin_r(sin_r), .sin_l(sin_l), .q(q2), .sout_l(sl2), .sout_r(sr2), .tc(tc2), .zero(z2));

    registrador_universal #(.WIDTH(8), .RST_VAL(64'h0)) dut_lo (
        .clk(clk), .rst(c_rst), .clr(c_zero_in), .en(c_en), .mode(c_mode), .d(c_d),
        .sin_r(c_zero_in), .sin_l(c_zero_in), .q(qlo), .sout_l(sllo), .sout_r(srlo), .tc(tclo), .zero(zlo));

    registrador_universal #(.WIDTH(8), .RST_VAL(64'h0)) dut_hi (
        .clk(clk), .rst(c_rst), .clr(c_zero_in), .en(tclo), .mode(c_mode), .d(c_d),
        .sin_r(c_zero_in), .sin_l(c_zero_in), .q(qhi), .sout_l(slhi), .sout_r(srhi), .tc(tchi), .zero(zhi));

    typedef struct {
        bit              known;
        longint unsigned q8;
        bit              tc8;
        longint unsigned q2;
        bit              tc2;
        bit              cknown;
        longint unsigned lo;
        longint unsigned hi;
        bit              tclo;
        bit              tchi;
        bit              pin8_v;
        longint unsigned pin8;
        bit              pin2_v;
        longint unsigned pin2;
        bit              pinc_v;
        longint unsigned pinc;
    } rec_t;

    rec_t sb[$];

    int checks = 0;
    int errors = 0;

    longint unsigned m8 = 0, m2 = 0, mc = 0;
    bit known = 1'b0, cknown = 1'b0;
    bit pin8_p = 1'b0, pin2_p = 1'b0, pinc_p = 1'b0;
    longint unsigned pin8_val = 0, pin2_val = 0, pinc_val = 0;

    // Register behaviour as plain modular arithmetic on an unsigned integer.
    function automatic longint unsigned model_next(input longint unsigned qv, input int w,
            input bit r, input bit c, input bit e, input mode_t md, input longint unsigned dv,
            input bit sr, input bit sl, input longint unsigned rv);
        longint unsigned m;
        longint unsigned half;
        m = 64'd1 << w;
        half = m / 2;
        if (r) return rv % m;
        if (c) return 0;
        if (!e) return qv;
        case (md)
            M_LOAD:  return dv % m;
            M_SHL:   return (qv * 2 + longint'(sr)) % m;
            M_SHR:   return qv / 2 + longint'(sl) * half;
            M_ROL:   return (qv * 2) % m + qv / half;
            M_ROR:   return qv / 2 + (qv % 2) * half;
            M_INC:   return (qv + 1) % m;
            M_DEC:   return (qv + m - 1) % m;
            default: return qv;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string nm, input logic [63:0] qv, input logic sl, input logic sr,
            input logic z, input longint unsigned exp, input int w);
        check({nm, "_q"}, qv, 64'(exp));
        check({nm, "_sout_l"}, 64'(sl), 64'((exp >> (w - 1)) & 1));
        check({nm, "_sout_r"}, 64'(sr), 64'(exp & 1));
        check({nm, "_zero"}, 64'(z), 64'(exp == 0));
    endtask

    task automatic pin8(input longint unsigned v); pin8_p = 1'b1; pin8_val = v; endtask
    task automatic pin2(input longint unsigned v); pin2_p = 1'b1; pin2_val = v; endtask
    task automatic pinc(input longint unsigned v); pinc_p = 1'b1; pinc_val = v; endtask

    // Drive one cycle and queue the outputs expected while these inputs are applied.
    task automatic step(input bit r, input bit c, input bit e, input mode_t md, input logic [7:0] dv,
            input bit sr, input bit sl, input bit cr, input bit ce);
        rec_t rec;
        @(posedge clk);
        #1;
        rst = r; clr = c; en = e; mode = md; d = dv; sin_r = sr; sin_l = sl;
        c_rst = cr; c_en = ce;
        rec.known  = known;
        rec.q8     = m8;
        rec.tc8    = e && ((md == M_INC && m8 == 255) || (md == M_DEC && m8 == 0));
        rec.q2     = m2;
        rec.tc2    = e && ((md == M_INC && m2 == 3) || (md == M_DEC && m2 == 0));
        rec.cknown = cknown;
        rec.lo     = mc % 256;
        rec.hi     = mc / 256;
        rec.tclo   = ce && (mc % 256 == 255);
        rec.tchi   = ce && (mc == 65535);
        rec.pin8_v = pin8_p; rec.pin8 = pin8_val; pin8_p = 1'b0;
        rec.pin2_v = pin2_p; rec.pin2 = pin2_val; pin2_p = 1'b0;
        rec.pinc_v = pinc_p; rec.pinc = pinc_val; pinc_p = 1'b0;
        sb.push_back(rec);
        m8 = model_next(m8, 8, r, c, e, md, longint'(dv), sr, sl, 64'hA5);
        m2 = model_next(m2, 2, r, c, e, md, longint'(dv), sr, sl, 64'h6);
        if (r) known = 1'b1;
        if (cr) begin
            mc = 0;
            cknown = 1'b1;
        end else if (ce) begin
            mc = (mc + 1) % 65536;
        end
    endtask

    task automatic op(input mode_t md, input logic [7:0] dv, input bit sr, input bit sl);
        step(1'b0, 1'b0, 1'b1, md, dv, sr, sl, 1'b0, 1'b0);
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                if (r.known) begin
                    check_outs("w8", 64'(q8), sl8, sr8, z8, r.q8, 8);
                    check("w8_tc", 64'(tc8), 64'(r.tc8));
                    check_outs("w2", 64'(q2), sl2, sr2, z2, r.q2, 2);
                    check("w2_tc", 64'(tc2), 64'(r.tc2));
                end
                if (r.pin8_v) check("w8_directed", 64'(q8), 64'(r.pin8));
                if (r.pin2_v) check("w2_directed", 64'(q2), 64'(r.pin2));
                if (r.cknown) begin
                    check_outs("lo", 64'(qlo), sllo, srlo, zlo, r.lo, 8);
                    check_outs("hi", 64'(qhi), slhi, srhi, zhi, r.hi, 8);
                    check("lo_tc", 64'(tclo), 64'(r.tclo));
                    check("hi_tc", 64'(tchi), 64'(r.tchi));
                end
                if (r.pinc_v) check("cascade_directed", 64'({qhi, qlo}), 64'(r.pinc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected completion before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset, reset with clear, clear alone.
        step(1, 0, 0, M_HOLD, 8'h00, 0, 0, 1, 0); pin8(64'hA5); pin2(2);
        step(1, 1, 1, M_INC,  8'h00, 0, 0, 1, 0); pin8(64'hA5); pin2(2);
        step(0, 1, 0, M_HOLD, 8'h00, 0, 0, 0, 0); pin8(64'h00); pin2(0);
        // Load, hold under en=0, shift both ways.
        op(M_LOAD, 8'h3C, 0, 0); pin8(64'h3C);
        repeat (3) step(0, 0, 0, M_SHL, 8'hFF, 1, 1, 0, 0);
        pin8(64'h3C);
        op(M_SHL, 8'h00, 1, 1); pin8(64'h79);
        op(M_SHR, 8'h00, 1, 0); pin8(64'h3C);
        // Rotates.
        op(M_LOAD, 8'h81, 1, 1); pin8(64'h81);
        op(M_ROL, 8'h00, 0, 0);  pin8(64'h03);
        op(M_ROR, 8'h00, 0, 0);
        op(M_ROR, 8'h00, 1, 1);  pin8(64'hC0);
        // Increment/decrement wrap with terminal count.
        op(M_LOAD, 8'hFE, 0, 0); pin8(64'hFE);
        op(M_INC, 8'h00, 0, 0);  pin8(64'hFF);
        op(M_INC, 8'h00, 0, 0);  pin8(64'h00);
        op(M_DEC, 8'h00, 0, 0);  pin8(64'hFF);
        // Reset in the middle of a count.
        op(M_LOAD, 8'h56, 0, 0);
        op(M_INC, 8'h00, 0, 0);  pin8(64'h57);
        step(1, 0, 1, M_INC, 8'h00, 0, 0, 0, 0); pin8(64'hA5); pin2(2);
        op(M_INC, 8'h00, 0, 0);  pin8(64'hA6);
        op(M_INC, 8'h00, 0, 0);  pin8(64'hA7);
        // Two-bit wrap.
        step(0, 1, 0, M_HOLD, 8'h00, 0, 0, 0, 0); pin2(0);
        repeat (3) op(M_INC, 8'h00, 0, 0);
        pin2(3);
        op(M_INC, 8'h00, 0, 0); pin2(0);
        op(M_DEC, 8'h00, 0, 0); pin2(3);
        // Cascaded pair counts 256 from zero.
        step(0, 0, 0, M_HOLD, 8'h00, 0, 0, 1, 0); pinc(0);
        repeat (256) step(0, 0, 0, M_HOLD, 8'h00, 0, 0, 0, 1);
        pinc(64'h0100);
        // Randomised traffic on all instances.
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 40) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                 mode_t'($urandom_range(0, 7)), 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom % 200) == 0, ($urandom % 3) != 0);
        end
        step(0, 0, 0, M_HOLD, 8'h00, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
